y86_stage_ctrl: RTL

Multi-cycle stage sequencer for the Y86-64 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and shares one single-port memory between instruction fetch and data access through a req/ack handshake. It also generates the PC, register-file, condition-code and instruction-latch enables that the single-cycle datapath currently applies on every clock. It sits between the top level and the PC, Regs, CC and Mem instances.

---
 rtl/y86_pkg.sv | 48 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/y86_stage_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 stage sequencer: opcodes, memory status,
// stage codes and the per-opcode decode predicates.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        ERROR     = 3'd7
    } stage_t;

    function automatic logic needs_mem(input logic [3:0] ic);
        return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

    function automatic logic mem_is_write(input logic [3:0] ic);
        return ic inside {IRMMOVQ, ICALL, IPUSHQ};
    endfunction

    function automatic logic needs_wb(input logic [3:0] ic);
        return ic inside {IRRMOVQ, IIRMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory-request cycles; expired flags the last
// permitted wait cycle so the sequencer can bail out on the next edge.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // An ack in this cycle drops waiting, so the ack always wins over expiry.
    assign expired = waiting && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (waiting && count != 8'hFF)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/y86_stage_ctrl.sv
// Multi-cycle stage sequencer: steps each instruction through the five stages,
// arbitrates the shared memory port and generates the datapath enables.
module y86_stage_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       icode,
    input  logic [1:0]       stat,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_we,
    output logic             fetch_en,
    output logic             cc_en,
    output logic             reg_we,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    stage_t stateQ, stateNext;
    logic   tmrExpired, tmrClear, waiting, statOk;

    // Request is a pure function of state so the timer sees no loop through the FSM.
    assign mem_req = (stateQ == FETCH) || (stateQ == MEMORY);
    assign waiting = mem_req && !mem_ack;
    assign statOk  = (stat_t'(stat) == STAT_AOK);
    assign tmrClear = mem_ack || (stateNext != stateQ);

    assign state  = stateQ;
    assign halted = (stateQ == HALT);
    assign error  = (stateQ == ERROR);

    mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) uTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmrClear),
        .waiting (waiting),
        .expired (tmrExpired)
    );

    always_comb begin
        stateNext = stateQ;
        mem_sel   = 1'b0;
        mem_we    = 1'b0;
        fetch_en  = 1'b0;
        cc_en     = 1'b0;
        reg_we    = 1'b0;
        pc_en     = 1'b0;
        case (stateQ)
            IDLE:
                if (run) stateNext = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    fetch_en  = 1'b1;
                    stateNext = statOk ? DECODE : ERROR;
                end else if (tmrExpired) begin
                    stateNext = ERROR;
                end
            end
            DECODE: begin
                if (icode > IPOPQ)
                    stateNext = ERROR;
                else if (icode == IHALT)
                    stateNext = HALT;
                else
                    stateNext = EXECUTE;
            end
            EXECUTE: begin
                cc_en     = (icode == IOPQ);
                stateNext = needs_mem(icode) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                mem_sel = 1'b1;
                mem_we  = mem_is_write(icode);
                if (mem_ack)
                    stateNext = statOk ? WRITEBACK : ERROR;
                else if (tmrExpired)
                    stateNext = ERROR;
            end
            WRITEBACK: begin
                reg_we    = needs_wb(icode);
                pc_en     = 1'b1;
                stateNext = run ? FETCH : IDLE;
            end
            HALT:    stateNext = HALT;
            ERROR:   stateNext = ERROR;
            default: stateNext = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            stateQ <= stateNext;
            if (stateQ inside {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pc_en && instr_cnt != '1)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule
